// File: rtl/column_io_pkg.sv
// Shared types and helpers for the column I/O controller.
//   state_t    : controller sequencing states
//   addr_width : column-address width, never narrower than one bit
package column_io_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_SENSE = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  // max(1, clog2(n)); also used to size the phase counter.
  function automatic int addr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/column_decoder.sv
// One-hot column-group decoder.
// Ports:
//   en     in  1          decode enable; output is all-zero when low
//   addr   in  CW         column-group address
//   onehot out NUM_WORDS  bit addr set when enabled and addr < NUM_WORDS
module column_decoder
  import column_io_pkg::*;
#(
  parameter int NUM_WORDS = 16,
  localparam int CW = addr_width(NUM_WORDS)
) (
  input  logic                 en,
  input  logic [CW-1:0]        addr,
  output logic [NUM_WORDS-1:0] onehot
);

  // Addresses at or above NUM_WORDS match no output, so out-of-range
  // requests decode to zero without a separate compare.
  generate
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_dec
      assign onehot[gi] = en && (addr == CW'(gi));
    end
  endgenerate

endmodule

// File: rtl/column_io_ctrl.sv
// Sequenced column I/O controller between the SRAM bit-cell array and the
// word-level port. One request per handshake; runs precharge followed by
// sense (read) or write-drive (write), then a one-cycle response.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req_valid/req_ready, req_we, req_col, req_wdata   request handshake
//   col_data_in   sensed column values from the array
//   precharge_en, sense_en, wr_en, col_select, col_wdata   array controls
//   rsp_valid, rsp_err, rsp_rdata                          response
module column_io_ctrl
  import column_io_pkg::*;
#(
  parameter int WORD_SIZE        = 4,
  parameter int NUM_WORDS        = 16,
  parameter int PRECHARGE_CYCLES = 1,
  parameter int SENSE_CYCLES     = 1,
  parameter int WRITE_CYCLES     = 1,
  localparam int CW       = addr_width(NUM_WORDS),
  localparam int NUM_COLS = WORD_SIZE * NUM_WORDS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [CW-1:0]        req_col,
  input  logic [WORD_SIZE-1:0] req_wdata,
  input  logic [NUM_COLS-1:0]  col_data_in,
  output logic                 precharge_en,
  output logic                 sense_en,
  output logic                 wr_en,
  output logic [NUM_WORDS-1:0] col_select,
  output logic [NUM_COLS-1:0]  col_wdata,
  output logic                 rsp_valid,
  output logic                 rsp_err,
  output logic [WORD_SIZE-1:0] rsp_rdata
);

  // Illegal geometries or zero-length phases stop elaboration.
  generate
    if (PRECHARGE_CYCLES < 1 || SENSE_CYCLES < 1 || WRITE_CYCLES < 1) begin : g_bad_cycles
      $fatal(1, "column_io_ctrl: phase cycle counts must be >= 1");
    end
    if (NUM_WORDS < 2) begin : g_bad_words
      $fatal(1, "column_io_ctrl: NUM_WORDS must be >= 2");
    end
  endgenerate

  // The phase counter only has to reach the longest phase length minus one.
  localparam int CNT_MAX_PS = (PRECHARGE_CYCLES > SENSE_CYCLES) ? PRECHARGE_CYCLES : SENSE_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_PS > WRITE_CYCLES) ? CNT_MAX_PS : WRITE_CYCLES;
  localparam int CNT_W      = addr_width(CNT_MAX);

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;

  // Request fields captured on the accept edge.
  logic                   we_reg;
  logic [CW-1:0]          col_reg;
  logic [WORD_SIZE-1:0]   wdata_reg;
  logic                   col_ok_reg;
  logic [WORD_SIZE-1:0]   rdata_reg;

  logic                   accept;
  logic                   pre_done, sense_done, write_done;
  logic                   array_en;
  logic [NUM_WORDS-1:0]   req_hit;
  logic                   req_col_ok;
  logic [WORD_SIZE-1:0]   sense_word;

  assign accept     = req_valid && req_ready;
  assign pre_done   = (cnt_reg == CNT_W'(PRECHARGE_CYCLES - 1));
  assign sense_done = (cnt_reg == CNT_W'(SENSE_CYCLES - 1));
  assign write_done = (cnt_reg == CNT_W'(WRITE_CYCLES - 1));

  // Range check of the incoming address: an enabled decode that hits no
  // output means the column group does not exist.
  column_decoder #(.NUM_WORDS(NUM_WORDS)) u_range_dec (
    .en     (1'b1),
    .addr   (req_col),
    .onehot (req_hit)
  );
  assign req_col_ok = |req_hit;

  // Column-group select, driven only from registered state and address.
  column_decoder #(.NUM_WORDS(NUM_WORDS)) u_sel_dec (
    .en     (array_en),
    .addr   (col_reg),
    .onehot (col_select)
  );

  // Write data lands only on the selected slice; every other slice is zero.
  generate
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_wdata
      assign col_wdata[gi*WORD_SIZE +: WORD_SIZE] =
        (wr_en && col_select[gi]) ? wdata_reg : '0;
    end
  endgenerate

  // Word mux for the sensed data, keyed by the one-hot select so that no
  // variable part-select is needed.
  always_comb begin
    sense_word = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (col_select[i]) begin
        sense_word = sense_word | col_data_in[i*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic. Out-of-range requests go straight from precharge to
  // the response so the array is never driven for them.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) state_next = ST_PRE;
      end
      ST_PRE: begin
        if (pre_done) begin
          if (!col_ok_reg)  state_next = ST_RESP;
          else if (we_reg)  state_next = ST_WRITE;
          else              state_next = ST_SENSE;
        end
      end
      ST_SENSE: begin
        if (sense_done) state_next = ST_RESP;
      end
      ST_WRITE: begin
        if (write_done) state_next = ST_RESP;
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Counter restarts at every phase change and idles at zero.
    if (state_next != state_reg || state_reg == ST_IDLE || state_reg == ST_RESP) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // Output decode from registered state only; req_ready is additionally
  // held low while reset is asserted.
  always_comb begin
    req_ready    = (state_reg == ST_IDLE) && !rst;
    precharge_en = (state_reg == ST_PRE);
    sense_en     = (state_reg == ST_SENSE);
    wr_en        = (state_reg == ST_WRITE);
    array_en     = (state_reg == ST_SENSE) || (state_reg == ST_WRITE);
    rsp_valid    = (state_reg == ST_RESP);
    rsp_err      = (state_reg == ST_RESP) && !col_ok_reg;
  end

  // Request capture and read-data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_reg     <= 1'b0;
      col_reg    <= '0;
      wdata_reg  <= '0;
      col_ok_reg <= 1'b0;
      rdata_reg  <= '0;
    end else begin
      if (accept) begin
        we_reg     <= req_we;
        col_reg    <= req_col;
        wdata_reg  <= req_wdata;
        col_ok_reg <= req_col_ok;
      end
      // Read data is taken on the last sense edge, when the sense amps
      // have had the full SENSE_CYCLES to settle.
      if (state_reg == ST_SENSE && sense_done) begin
        rdata_reg <= sense_word;
      end
    end
  end

  assign rsp_rdata = rdata_reg;

endmodule

// File: tb/tb_column_io_ctrl.sv
// Self-checking bench for column_io_ctrl. Three instances cover the default
// geometry, longer phase counts, and a non-power-of-2 word count. Expected
// behaviour is derived per cycle from the phase timeline of each request.
module tb_column_io_ctrl;

  localparam int PP  [3] = '{1, 2, 1};
  localparam int SS  [3] = '{1, 3, 2};
  localparam int WW  [3] = '{1, 2, 3};
  localparam int NW  [3] = '{16, 16, 12};
  localparam int WSZ [3] = '{4, 4, 8};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Shared request fields; req_valid is routed to the selected instance.
  int         cur = 0;
  logic       req_valid = 1'b0;
  logic       req_we = 1'b0;
  logic [3:0] req_col = '0;
  logic [7:0] req_wdata = '0;

  logic        rv_a, rdy_a, pre_a, sen_a, wr_a, vld_a, err_a;
  logic [15:0] sel_a;
  logic [63:0] cwd_a, din_a = '0;
  logic [3:0]  rd_a;
  logic        rv_b, rdy_b, pre_b, sen_b, wr_b, vld_b, err_b;
  logic [15:0] sel_b;
  logic [63:0] cwd_b, din_b = '0;
  logic [3:0]  rd_b;
  logic        rv_c, rdy_c, pre_c, sen_c, wr_c, vld_c, err_c;
  logic [11:0] sel_c;
  logic [95:0] cwd_c, din_c = '0;
  logic [7:0]  rd_c;

  assign rv_a = req_valid && (cur == 0);
  assign rv_b = req_valid && (cur == 1);
  assign rv_c = req_valid && (cur == 2);

  column_io_ctrl u_a (
    .clk(clk), .rst(rst), .req_valid(rv_a), .req_ready(rdy_a), .req_we(req_we),
    .req_col(req_col), .req_wdata(req_wdata[3:0]), .col_data_in(din_a),
    .precharge_en(pre_a), .sense_en(sen_a), .wr_en(wr_a), .col_select(sel_a),
    .col_wdata(cwd_a), .rsp_valid(vld_a), .rsp_err(err_a), .rsp_rdata(rd_a)
  );

  column_io_ctrl #(.PRECHARGE_CYCLES(2), .SENSE_CYCLES(3), .WRITE_CYCLES(2)) u_b (
    .clk(clk), .rst(rst), .req_valid(rv_b), .req_ready(rdy_b), .req_we(req_we),
    .req_col(req_col), .req_wdata(req_wdata[3:0]), .col_data_in(din_b),
    .precharge_en(pre_b), .sense_en(sen_b), .wr_en(wr_b), .col_select(sel_b),
    .col_wdata(cwd_b), .rsp_valid(vld_b), .rsp_err(err_b), .rsp_rdata(rd_b)
  );

  column_io_ctrl #(.WORD_SIZE(8), .NUM_WORDS(12), .PRECHARGE_CYCLES(1),
                   .SENSE_CYCLES(2), .WRITE_CYCLES(3)) u_c (
    .clk(clk), .rst(rst), .req_valid(rv_c), .req_ready(rdy_c), .req_we(req_we),
    .req_col(req_col), .req_wdata(req_wdata), .col_data_in(din_c),
    .precharge_en(pre_c), .sense_en(sen_c), .wr_en(wr_c), .col_select(sel_c),
    .col_wdata(cwd_c), .rsp_valid(vld_c), .rsp_err(err_c), .rsp_rdata(rd_c)
  );

  // Observation view of the selected instance.
  logic        o_ready, o_pre, o_sense, o_wr, o_valid, o_err;
  logic [15:0] o_sel;
  logic [95:0] o_wd;
  logic [7:0]  o_rd;

  always_comb begin
    o_ready = 1'b0; o_pre = 1'b0; o_sense = 1'b0; o_wr = 1'b0;
    o_valid = 1'b0; o_err = 1'b0; o_sel = '0; o_wd = '0; o_rd = '0;
    case (cur)
      0: begin
        o_ready = rdy_a; o_pre = pre_a; o_sense = sen_a; o_wr = wr_a;
        o_valid = vld_a; o_err = err_a; o_sel = sel_a; o_wd = 96'(cwd_a); o_rd = 8'(rd_a);
      end
      1: begin
        o_ready = rdy_b; o_pre = pre_b; o_sense = sen_b; o_wr = wr_b;
        o_valid = vld_b; o_err = err_b; o_sel = sel_b; o_wd = 96'(cwd_b); o_rd = 8'(rd_b);
      end
      default: begin
        o_ready = rdy_c; o_pre = pre_c; o_sense = sen_c; o_wr = wr_c;
        o_valid = vld_c; o_err = err_c; o_sel = 16'(sel_c); o_wd = cwd_c; o_rd = rd_c;
      end
    endcase
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] rd_model [3] = '{8'h0, 8'h0, 8'h0};

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut=%0d actual=%0h required=%0h", nm, cur, act, req);
    end
  endfunction

  task automatic set_din(input int d, input logic [95:0] din);
    case (d)
      0: din_a = din[63:0];
      1: din_b = din[63:0];
      default: din_c = din;
    endcase
  endtask

  // One request on instance d, checked every cycle from accept to the
  // first ready cycle after the response.
  task automatic run_txn(input int d, input bit we, input int col, input logic [7:0] wd,
                         input logic [95:0] din, output int rcyc,
                         output logic [15:0] sel_or, output logic [95:0] wd_or);
    int p, l, r, m, k;
    bit inr;
    logic [7:0]  word, old_rd, rd_e;
    logic [95:0] wexp;
    p = PP[d];
    l = we ? WW[d] : SS[d];
    inr = (col < NW[d]);
    r = inr ? p + l + 1 : p + 1;
    m = (1 << WSZ[d]) - 1;
    word = 8'((din >> (col * WSZ[d])) & 96'(m));
    wexp = (96'(wd) & 96'(m)) << (col * WSZ[d]);
    old_rd = rd_model[d];
    rcyc = -1; sel_or = '0; wd_or = '0;

    @(negedge clk);
    cur = d;
    set_din(d, din);
    req_we = we; req_col = 4'(col); req_wdata = wd; req_valid = 1'b1;
    #1;
    k = 0;
    while (!o_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!o_ready) begin
      chk("accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    // Request fields are free to change after the accept edge.
    req_valid = 1'b0; req_col = 4'($urandom); req_wdata = 8'($urandom); req_we = 1'($urandom);

    for (int c = 1; c <= r + 1; c++) begin
      bit act;
      @(negedge clk);
      act = inr && (c > p) && (c <= p + l);
      rd_e = (c >= r && !we && inr) ? word : old_rd;
      chk("precharge_en", o_pre, c <= p);
      chk("sense_en", o_sense, act && !we);
      chk("wr_en", o_wr, act && we);
      chk("col_select", o_sel, act ? 16'(1 << col) : 16'h0);
      chk("col_wdata", o_wd, (act && we) ? wexp : 96'h0);
      chk("rsp_valid", o_valid, c == r);
      chk("rsp_err", o_err, (c == r) && !inr);
      chk("req_ready", o_ready, c == r + 1);
      chk("rsp_rdata", o_rd, rd_e);
      if (o_valid && rcyc < 0) rcyc = c;
      sel_or = sel_or | o_sel;
      wd_or  = wd_or | o_wd;
    end
    if (!we && inr) rd_model[d] = word;
    $display("txn dut=%0d we=%0d col=%0d wdata=%h resp_cycle=%0d rdata=%h err=%0d",
             d, we, col, wd, rcyc, o_rd, !inr);
  endtask

  // req_valid held high with alternating reads/writes: accepts must be
  // spaced by the full sequence length and each gets exactly one response.
  task automatic throughput(input int d, input int ncyc);
    int last, acc, rsp, col, m;
    bit prev_we;
    logic [95:0] din;
    din = {$urandom, $urandom, $urandom};
    col = $urandom_range(0, NW[d] - 1);
    m = (1 << WSZ[d]) - 1;
    @(posedge clk);
    #1;
    cur = d;
    set_din(d, din);
    req_col = 4'(col); req_wdata = 8'($urandom); req_we = 1'b0; req_valid = 1'b1;
    last = -1; acc = 0; rsp = 0; prev_we = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (o_valid) rsp++;
      if (o_ready) begin
        if (last >= 0) begin
          chk("accept_period", c - last, prev_we ? PP[d] + WW[d] + 2 : PP[d] + SS[d] + 2);
        end
        $display("txn dut=%0d back_to_back accept cycle=%0d we=%0d", d, c, req_we);
        last = c; prev_we = req_we; acc++;
        @(posedge clk);
        #1;
        req_we = ~req_we;
        req_wdata = 8'($urandom);
      end
    end
    req_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (o_valid) rsp++;
    end
    chk("rsp_count", rsp, acc);
    rd_model[d] = 8'((din >> (col * WSZ[d])) & 96'(m));
    chk("rdata_after_stream", o_rd, rd_model[d]);
  endtask

  typedef struct {
    int          d;
    bit          we;
    int          col;
    logic [7:0]  wd;
    logic [95:0] din;
    logic [7:0]  exp_rd;
    int          exp_rcyc;
    logic [15:0] exp_sel;
    logic [95:0] exp_wd;
  } vec_t;

  vec_t tbl [7];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int rcyc;
    logic [15:0] sel_or;
    logic [95:0] wd_or;

    tbl[0] = '{0, 1'b0, 5,  8'h00, 96'h0123_4567_89AB_CDEF, 8'h0A, 3, 16'h0020, 96'h0};
    tbl[1] = '{0, 1'b1, 15, 8'h09, 96'h0123_4567_89AB_CDEF, 8'h0A, 3, 16'h8000,
               96'h9000_0000_0000_0000};
    tbl[2] = '{1, 1'b0, 0,  8'h00, 96'h0000_0000_0000_0007, 8'h07, 6, 16'h0001, 96'h0};
    tbl[3] = '{2, 1'b0, 3,  8'h00, 96'h0B0A_0908_0706_0504_0302_0100, 8'h03, 4, 16'h0008, 96'h0};
    tbl[4] = '{2, 1'b0, 13, 8'h00, 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 8'h03, 2, 16'h0000, 96'h0};
    tbl[5] = '{2, 1'b1, 11, 8'hA5, 96'h0, 8'h03, 5, 16'h0800,
               96'hA500_0000_0000_0000_0000_0000};
    tbl[6] = '{2, 1'b1, 12, 8'hFF, 96'h0, 8'h03, 2, 16'h0000, 96'h0};

    // Reset state on every instance.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      cur = d;
      #1;
      chk("reset_ready", o_ready, 0);
      chk("reset_outputs", {o_pre, o_sense, o_wr, o_valid, o_err, o_sel, o_wd}, 0);
      chk("reset_rdata", o_rd, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      cur = d;
      #1;
      chk("ready_after_reset", o_ready, 1);
    end

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      run_txn(tbl[i].d, tbl[i].we, tbl[i].col, tbl[i].wd, tbl[i].din, rcyc, sel_or, wd_or);
      chk("tbl_resp_cycle", rcyc, tbl[i].exp_rcyc);
      chk("tbl_rdata", o_rd, tbl[i].exp_rd);
      chk("tbl_col_select", sel_or, tbl[i].exp_sel);
      chk("tbl_col_wdata", wd_or, tbl[i].exp_wd);
    end

    // Continuous request streams.
    throughput(0, 30);
    throughput(1, 45);

    // Reset in the middle of a read on the long-phase instance.
    run_txn(1, 1'b0, 2, 8'h0, 96'h0000_0000_0000_0C00, rcyc, sel_or, wd_or);
    @(posedge clk);
    #1;
    cur = 1;
    din_b = 64'h0000_0000_0000_0005;
    req_we = 1'b0; req_col = 4'h0; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("sense_before_abort", o_sense, 1);
    chk("rdata_before_abort", o_rd, 8'h0C);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_outputs", {o_pre, o_sense, o_wr, o_valid, o_err, o_sel, o_wd}, 0);
    chk("abort_ready", o_ready, 0);
    chk("abort_rdata", o_rd, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int d = 0; d < 3; d++) rd_model[d] = 8'h0;
    @(negedge clk);
    chk("ready_after_abort", o_ready, 1);
    repeat (5) begin
      @(negedge clk);
      chk("no_rsp_after_abort", o_valid, 0);
    end

    // Randomized requests against the timeline model.
    for (int i = 0; i < 40; i++) begin
      int d;
      d = $urandom_range(0, 2);
      run_txn(d, 1'($urandom), $urandom_range(0, 15), 8'($urandom),
              {$urandom, $urandom, $urandom}, rcyc, sel_or, wd_or);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
